ct_ciu_vb_w_issue: RTL
======================

# ct_ciu_vb_w_issue

Write-issue engine for the CIU victim buffer. It takes one granted victim-buffer entry (address offset plus full 64-byte line with strobes) and serializes it onto the 128-bit AXI W channel as a 4-beat critical-word-first wrap burst. It then consumes the matching B response and emits the one-hot entry pop that frees the entry. It sits between the victim-buffer entry array (upstream) and the EBIU write port (downstream).

## Interface
- ENTRY, 8: number of victim-buffer entries; id width is log2(ENTRY)=3.
- BEATS, 4: W beats per line.
- DWIDTH, 128: W data width; line = BEATS*DWIDTH = 512 bits, strobe = 64 bits.

Ports:
- forever_cpuclk  in  1  clock; all state updates on the rising edge.
- cpurst_b  in  1  asynchronous, active-low reset.
- vb_w_req_vld  in  1  an entry has AW issued and W data valid; request to send.
- vb_w_req_id  in  3  entry index of the request.
- vb_w_req_data  in  512  line data; beat k = bits [128k+127:128k].
- vb_w_req_strb  in  64  byte strobes; beat k = bits [16k+15:16k].
- vb_w_req_offset  in  2  critical beat index (addr[5:4]).
- vb_w_req_grnt  out  1  request accepted this cycle.
- vb_ebiu_wvalid  out  1  AXI W valid.
- vb_ebiu_wdata  out  128  AXI W data.
- vb_ebiu_wstrb  out  16  AXI W strobe.
- vb_ebiu_wlast  out  1  AXI W last.
- ebiu_vb_wready  in  1  AXI W ready.
- ebiu_vb_bvalid  in  1  AXI B valid.
- ebiu_vb_bid  in  3  B id = entry index.
- ebiu_vb_bresp  in  2  B response.
- vb_ebiu_bready  out  1  AXI B ready.
- vb_w_pop_sel  out  8  one-hot entry pop.
- vb_w_bresp_err  out  1  one-cycle pulse for SLVERR/DECERR.
- vb_w_idle  out  1  no burst in flight and no B outstanding.

## Operation
- FSM states: IDLE, SEND. Reset -> IDLE.
- Grant: vb_w_req_grnt = vb_w_req_vld & (IDLE | (SEND & last-beat handshake)) & (outst_cnt != 8 or a B handshake occurs the same cycle). Combinational.
- On grant: latch data, strb, id, offset; beat_cnt<=0; cur_beat<=offset; state<=SEND.
- SEND: wvalid=1; wdata/wstrb = latched beat cur_beat; wlast = (beat_cnt==3).
- Beat handshake (wvalid & wready): beat_cnt+1; cur_beat+1 mod 4 (wraps 3->0).
- Last handshake: if grant in same cycle, reload and stay SEND (back-to-back, no bubble); otherwise -> IDLE.
- wvalid held and wdata/wstrb/wlast stable until wready (AXI rule); the latched line is never updated mid-burst.
- outst_cnt (0..8, 4 bits): +1 on last-beat handshake, -1 on B handshake; both same cycle -> unchanged.
- vb_ebiu_bready = 1 whenever outst_cnt != 0.
- vb_w_pop_sel = one-hot(ebiu_vb_bid) when bvalid & bready, else 0. Combinational; pops regardless of bresp.
- vb_w_bresp_err registered: 1 the cycle after B handshake with bresp[1]==1.
- vb_w_idle = IDLE & outst_cnt==0.

## Timing
- Reset values: wvalid=0, wlast=0, wdata=0, wstrb=0, grnt=0, bready=0, pop_sel=0, bresp_err=0, idle=1; outst_cnt=0, beat_cnt=0, cur_beat=0.
- Grant at cycle T -> wvalid at T+1; with wready held high, beats at T+1..T+4, wlast at T+4.
- Back-to-back: next line's first beat at T+5, no idle cycle.
- B may arrive no earlier than the cycle after its last-beat handshake; pop is same-cycle as the B handshake.
- Mid-operation reset: all state cleared immediately; in-flight burst is abandoned; entries are not popped.

## Test plan
- Reset, then req id=2 offset=0, wready=1 -> beats 0,1,2,3 at T+1..T+4; wlast only at T+4; idle=0 until B.
- Offset=2 -> beat order 2,3,0,1; wstrb follows the same order; wlast on beat 1.
- wready toggles 1,0,0,1,... -> wdata/wstrb/wlast stable during stalls; exactly 4 handshakes.
- Two requests back-to-back (id 1 then 5) -> 8 contiguous beats; grnt asserted on the first burst's last handshake.
- bvalid id=5 bresp=2'b10 -> pop_sel=8'b0010_0000 the same cycle; bresp_err=1 next cycle; outst_cnt decrements.
- Fill outst_cnt to 8 with no B -> grnt stays 0 with req_vld=1; a B arrives -> grant in that same cycle.

Source files
------------

// File: rtl/ct_ciu_vb_w_issue.sv
// Victim-buffer write-issue engine: serializes one granted line onto the AXI W channel as a
// critical-word-first wrap burst, then retires the entry on its B response.
module ct_ciu_vb_w_issue #(
    parameter int unsigned ENTRY  = 8,
    parameter int unsigned BEATS  = 4,
    parameter int unsigned DWIDTH = 128
) (
    input  logic                        forever_cpuclk,
    input  logic                        cpurst_b,
    input  logic                        vb_w_req_vld,
    input  logic [$clog2(ENTRY)-1:0]    vb_w_req_id,
    input  logic [BEATS*DWIDTH-1:0]     vb_w_req_data,
    input  logic [BEATS*DWIDTH/8-1:0]   vb_w_req_strb,
    input  logic [$clog2(BEATS)-1:0]    vb_w_req_offset,
    output logic                        vb_w_req_grnt,
    output logic                        vb_ebiu_wvalid,
    output logic [DWIDTH-1:0]           vb_ebiu_wdata,
    output logic [DWIDTH/8-1:0]         vb_ebiu_wstrb,
    output logic                        vb_ebiu_wlast,
    input  logic                        ebiu_vb_wready,
    input  logic                        ebiu_vb_bvalid,
    input  logic [$clog2(ENTRY)-1:0]    ebiu_vb_bid,
    input  logic [1:0]                  ebiu_vb_bresp,
    output logic                        vb_ebiu_bready,
    output logic [ENTRY-1:0]            vb_w_pop_sel,
    output logic                        vb_w_bresp_err,
    output logic                        vb_w_idle
);

    localparam int unsigned IDW = $clog2(ENTRY);
    localparam int unsigned BW  = $clog2(BEATS);
    localparam int unsigned OW  = $clog2(ENTRY + 1);
    localparam int unsigned SW  = DWIDTH / 8;

    localparam logic IDLE = 1'b0;
    localparam logic SEND = 1'b1;

    logic                          state_q, state_d;
    logic [BEATS-1:0][DWIDTH-1:0]  data_q;
    logic [BEATS-1:0][SW-1:0]      strb_q;
    logic [IDW-1:0]                id_q;
    logic [BW-1:0]                 beat_cnt_q, beat_cnt_d;
    logic [BW-1:0]                 cur_beat_q, cur_beat_d;
    logic [OW-1:0]                 outst_cnt_q, outst_cnt_d;
    logic                          bresp_err_q;

    logic w_hs;
    logic last_hs;
    logic b_hs;

    always_comb begin
        vb_ebiu_wvalid = (state_q == SEND);
        vb_ebiu_wdata  = vb_ebiu_wvalid ? data_q[cur_beat_q] : '0;
        vb_ebiu_wstrb  = vb_ebiu_wvalid ? strb_q[cur_beat_q] : '0;
        vb_ebiu_wlast  = vb_ebiu_wvalid & (beat_cnt_q == BW'(BEATS - 1));
        vb_ebiu_bready = (outst_cnt_q != '0);

        w_hs    = vb_ebiu_wvalid & ebiu_vb_wready;
        last_hs = w_hs & vb_ebiu_wlast;
        b_hs    = ebiu_vb_bvalid & vb_ebiu_bready;

        // A B retiring this cycle frees a slot for a request arriving at a full counter.
        vb_w_req_grnt = vb_w_req_vld & ((state_q == IDLE) | last_hs)
                      & ((outst_cnt_q != OW'(ENTRY)) | b_hs);

        vb_w_pop_sel   = b_hs ? (ENTRY'(1) << ebiu_vb_bid) : '0;
        vb_w_bresp_err = bresp_err_q;
        vb_w_idle      = (state_q == IDLE) & (outst_cnt_q == '0);
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        cur_beat_d = cur_beat_q;
        if (vb_w_req_grnt) begin
            state_d    = SEND;
            beat_cnt_d = '0;
            cur_beat_d = vb_w_req_offset;
        end else if (w_hs) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            cur_beat_d = cur_beat_q + 1'b1;
            if (last_hs) begin
                state_d = IDLE;
            end
        end

        outst_cnt_d = outst_cnt_q;
        case ({last_hs, b_hs})
            2'b10:   outst_cnt_d = outst_cnt_q + 1'b1;
            2'b01:   outst_cnt_d = outst_cnt_q - 1'b1;
            default: outst_cnt_d = outst_cnt_q;
        endcase
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            cur_beat_q  <= '0;
            outst_cnt_q <= '0;
            bresp_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            cur_beat_q  <= cur_beat_d;
            outst_cnt_q <= outst_cnt_d;
            bresp_err_q <= b_hs & ebiu_vb_bresp[1];
        end
    end

    // The line is captured only on grant so W stays stable across wready stalls.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            data_q <= '0;
            strb_q <= '0;
            id_q   <= '0;
        end else if (vb_w_req_grnt) begin
            data_q <= vb_w_req_data;
            strb_q <= vb_w_req_strb;
            id_q   <= vb_w_req_id;
        end
    end

endmodule
